// File: rtl/pa_AsyncCordic_pkg.sv
// Shared types for the async CORDIC datapath: dual-rail encoding plus the
// state and defaults of the synchronous result sink.
package pa_AsyncCordic;

   typedef struct packed {
      logic data_1;
      logic data_0;
   } dual_rail_t;

   typedef enum logic {
      WAIT_TOKEN,
      WAIT_NULL
   } sink_state_t;

   localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/dual_rail_completion.sv
// Combinational completion/spacer detection over a dual-rail bus.
module dual_rail_completion
   import pa_AsyncCordic::*;
#(
   parameter int SIZE = 31
) (
   input  dual_rail_t [SIZE:0] data_i,
   output logic                complete_o,
   output logic                null_o
);

   // A bit with both rails high still counts as arrived so the sink captures
   // it and flags the error instead of stalling the ring forever.
   always_comb begin
      complete_o = 1'b1;
      null_o     = 1'b1;
      for (int i = 0; i <= SIZE; i++) begin
         complete_o = complete_o & (data_i[i].data_1 | data_i[i].data_0);
         null_o     = null_o & ~(data_i[i].data_1 | data_i[i].data_0);
      end
   end

endmodule

// File: rtl/sync_chain.sv
// Multi-flop synchroniser with synchronous clear.
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] chain_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) chain_q <= '0;
      else       chain_q <= {chain_q[STAGES-2:0], d_i};
   end

   assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/async_result_sink.sv
// Four-phase dual-rail receiver that hands decoded tokens to a synchronous
// valid/ready consumer and acknowledges the upstream async source.
module async_result_sink
   import pa_AsyncCordic::*;
#(
   parameter int SIZE        = 31,
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  dual_rail_t [SIZE:0] data_i,
   output logic                ack_o,
   output logic [SIZE:0]       data_o,
   output logic                valid_o,
   input  logic                ready_i,
   output logic                err_o
);

   logic completeRaw, nullRaw, completeSync, nullSync;
   logic [SIZE:0] rail1, bothHigh;
   logic capture;

   sink_state_t   state_q, state_d;
   logic [SIZE:0] data_q, data_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;

   dual_rail_completion #(.SIZE(SIZE)) uCompletion (
      .data_i    (data_i),
      .complete_o(completeRaw),
      .null_o    (nullRaw)
   );

   sync_chain #(.STAGES(SYNC_STAGES)) uCompleteSync (
      .clk_i(clk_i), .rst_i(rst_i), .d_i(completeRaw), .q_o(completeSync)
   );

   sync_chain #(.STAGES(SYNC_STAGES)) uNullSync (
      .clk_i(clk_i), .rst_i(rst_i), .d_i(nullRaw), .q_o(nullSync)
   );

   always_comb begin
      for (int i = 0; i <= SIZE; i++) begin
         rail1[i]    = data_i[i].data_1;
         bothHigh[i] = data_i[i].data_1 & data_i[i].data_0;
      end
   end

   // Capturing only when the output slot is free or draining is what stalls
   // upstream under backpressure: ack stays low until the consumer catches up.
   assign capture = (state_q == WAIT_TOKEN) && completeSync && (!valid_q || ready_i);

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      valid_d = valid_q;
      err_d   = err_q;
      if (valid_q && ready_i) valid_d = 1'b0;
      case (state_q)
         WAIT_TOKEN: begin
            if (capture) begin
               data_d  = rail1;
               valid_d = 1'b1;
               err_d   = err_q | (|bothHigh);
               state_d = WAIT_NULL;
            end
         end
         WAIT_NULL: begin
            if (nullSync) state_d = WAIT_TOKEN;
         end
         default: state_d = WAIT_TOKEN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= WAIT_TOKEN;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign ack_o   = (state_q == WAIT_NULL);
   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign err_o   = err_q;

endmodule
